debounce_bank: RTL
==================

// Module: debounce_bank
// PURPOSE
//  - NCH-channel push-button conditioner. Replaces the fixed 3-bit, 40 Hz, two-sample chatter remover.
//  - Per channel: synchronise the raw pin, then sample it on a shared divided tick.
//  - Accept a new level only after STABLE consecutive agreeing samples.
//  - Outputs: the debounced level plus one-CLK press and release pulses.
//  - Sits between board button pins and the control FSMs.
// PARAMETERS
//  NCH           3           number of button channels
//  CLK_HZ        50000000    CLK frequency in Hz
//  SAMPLE_HZ     1000        sample tick rate; DIV = CLK_HZ/SAMPLE_HZ, must be >= 2
//  STABLE        8           consecutive agreeing samples needed to change level, >= 1
//  ACTIVE_LOW    1           1: pin low = pressed; 0: pin high = pressed
//  REPEAT_DELAY  500         ticks held before first auto-repeat (used only with macro)
//  REPEAT_PERIOD 100         ticks between auto-repeats (used only with macro)
// PORTS
//  CLK     in   1    system clock, rising edge
//  RST     in   1    asynchronous, active-high reset
//  BIN     in   NCH  raw button pins, asynchronous to CLK
//  LEVEL   out  NCH  debounced state, 1 = pressed
//  PRESS   out  NCH  1-CLK pulse on accepted press (and on repeats, see CONFIGURATION)
//  RELEASE out  NCH  1-CLK pulse on accepted release
//  TICK    out  1    1-CLK sample strobe, exported for other slow logic
// BEHAVIOUR
//  - Reset values:
//    - LEVEL, PRESS, RELEASE, TICK = 0; divider and all stability counters = 0.
//    - Synchroniser flops reset to the inactive pin value (1 if ACTIVE_LOW), so no press appears at reset exit.
//  - Divider:
//    - Counts 0..DIV-1 and wraps to 0.
//    - TICK is registered: high for the one CLK after the count reaches DIV-1.
//  - Synchroniser:
//    - 2 flops per channel, clocked every CLK.
//    - Output is normalised to active-high: s = sync ^ ACTIVE_LOW.
//  - Per-channel filter, acting only on TICK cycles:
//    - s == LEVEL: cnt <= 0.
//    - s != LEVEL and cnt == STABLE-1: LEVEL <= s, cnt <= 0, and the edge pulse fires in the same cycle.
//    - Otherwise: cnt <= cnt+1.
//    - cnt width = clog2(STABLE+1).
//  - Edge pulses:
//    - PRESS = LEVEL 0->1; RELEASE = LEVEL 1->0.
//    - Each pulse is registered, exactly 1 CLK wide, and asserted in the cycle LEVEL changes.
//  - Latency from a clean pin edge to LEVEL change: 2 CLK sync, plus the wait to the next TICK, plus (STABLE-1)*DIV CLK.
//  - Any disagreeing sample (bounce) clears cnt; bounce shorter than STABLE ticks never changes LEVEL.
//  - Channels are fully independent. Simultaneous events produce coincident pulses on every affected bit.
//  - RST mid-count: counters clear immediately, no pulse is emitted, LEVEL returns to 0.
// CONFIGURATION
//  - Macro DEBOUNCE_AUTO_REPEAT_EN defined: each channel gets a repeat counter (ticks held).
//    - Counter clears when LEVEL = 0.
//    - While LEVEL = 1: an extra PRESS pulse fires on the TICK where held == REPEAT_DELAY.
//    - Then one more every REPEAT_PERIOD ticks; the counter saturates, it does not wrap.
//    - RELEASE is unaffected.
//  - Macro undefined: no repeat logic; PRESS fires once per accepted press; REPEAT_* parameters are ignored.
// STRUCTURE
//  - Package debounce_pkg: clog2 function and the DIV localparam calculation.
//  - Sub-module debounce_chan: synchroniser, filter counter, LEVEL, edge pulses, optional repeat counter.
//    - Instantiated NCH times via generate.
//  - Top (debounce_bank): divider, TICK, and channel array.
// TESTING (bench params: CLK_HZ=1000, SAMPLE_HZ=100 -> DIV=10, STABLE=4, NCH=3, ACTIVE_LOW=1)
//  - Reset, BIN=3'b111 held 200 CLK
//    -> all outputs 0; TICK every 10 CLK; no PRESS/RELEASE.
//  - BIN[0] 1->0 cleanly
//    -> LEVEL[0]=1 and a single PRESS[0] pulse within 2+10+30 CLK; other bits stay 0.
//  - BIN[1] toggles every 15 CLK for 120 CLK, then held 0
//    -> exactly one PRESS[1], only after the final settle.
//  - BIN[0]=0 and BIN[2]=0 in the same CLK
//    -> PRESS[0], PRESS[2] coincident; later release of both -> coincident RELEASE[0], RELEASE[2].
//  - RST pulsed after 3 agreeing ticks of a press
//    -> no PRESS, LEVEL=0; a fresh press then needs a full 4 ticks.
//  - With DEBOUNCE_AUTO_REPEAT_EN, REPEAT_DELAY=5, REPEAT_PERIOD=2, BIN[0] held 0
//    -> PRESS[0] at accept, then at +5, +7, +9 ticks; it stops on release.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared helpers for the push-button debounce bank.
//   - clog2    : bit width needed to hold values 0..value-1 (never less than 1)
//   - calc_div : clock cycles per sample tick (CLK_HZ / SAMPLE_HZ)
//   No ports; imported by debounce_chan and debounce_bank.
//   Optional feature macro used elsewhere in the slice: DEBOUNCE_AUTO_REPEAT_EN.

package debounce_pkg;

  // Width of a counter that must represent 0..value-1. A minimum of one bit
  // keeps degenerate parameter choices from producing zero-width vectors.
  function automatic int clog2(input longint value);
    int width;
    width = 1;
    while ((longint'(1) << width) < value) begin
      width++;
    end
    return width;
  endfunction

  function automatic int calc_div(input longint clk_hz, input longint sample_hz);
    return int'(clk_hz / sample_hz);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// debounce_chan
//   One button channel: two-flop synchroniser, tick-driven stability filter,
//   debounced level and registered one-cycle press/release pulses.
//   Optional auto-repeat of PRESS while held (macro DEBOUNCE_AUTO_REPEAT_EN).
// Ports
//   CLK    in  1  system clock, rising edge
//   RST    in  1  asynchronous active-high reset
//   tick   in  1  shared one-cycle sample strobe
//   pin    in  1  raw button pin, asynchronous to CLK
//   level  out 1  debounced state, 1 = pressed
//   press  out 1  one-cycle pulse on accepted press (and on repeats when enabled)
//   rel    out 1  one-cycle pulse on accepted release

module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE        = 8,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic CLK,
  input  logic RST,
  input  logic tick,
  input  logic pin,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int   CW       = clog2(STABLE + 1);
  localparam logic INACTIVE = (ACTIVE_LOW != 0);

  if (STABLE < 1) begin : g_bad_stable
    $error("debounce_chan: STABLE must be at least 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("debounce_chan: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  logic [1:0]    sync_q;
  logic          s;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          rep_fire;

  // Synchroniser flops start at the idle pin value so leaving reset never
  // looks like a press.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= {INACTIVE, INACTIVE};
    end else begin
      sync_q <= {sync_q[0], pin};
    end
  end

  assign s = sync_q[1] ^ INACTIVE;

  // A new level is accepted on the tick that delivers the STABLE-th
  // consecutive disagreeing sample.
  always_comb begin
    accept = 1'b0;
    if (tick && (s != level) && (cnt == CW'(STABLE - 1))) begin
      accept = 1'b1;
    end
  end

  // Filter counter and level. Any agreeing sample clears the run, so a bounce
  // restarts the count from zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (tick) begin
      if (s == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Pulses are registered alongside level so they coincide with its change.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= (accept && s) || rep_fire;
      rel   <= accept && !s;
    end
  end

`ifdef DEBOUNCE_AUTO_REPEAT_EN
  localparam int HW = clog2(REPEAT_DELAY + 1);
  localparam int PW = clog2(REPEAT_PERIOD + 1);

  logic [HW-1:0] held;
  logic [PW-1:0] phase;

  // held counts ticks since the press was accepted and parks at REPEAT_DELAY;
  // from then on phase paces the periodic repeats. A tick that accepts a
  // release never repeats.
  always_comb begin
    rep_fire = 1'b0;
    if (tick && level && !accept) begin
      if (held == HW'(REPEAT_DELAY - 1)) begin
        rep_fire = 1'b1;
      end else if ((held == HW'(REPEAT_DELAY)) && (phase == PW'(REPEAT_PERIOD - 1))) begin
        rep_fire = 1'b1;
      end
    end
  end

  // Repeat state is held clear whenever the button is not pressed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      held  <= '0;
      phase <= '0;
    end else if (!level) begin
      held  <= '0;
      phase <= '0;
    end else if (tick) begin
      if (held != HW'(REPEAT_DELAY)) begin
        held <= held + HW'(1);
      end else if (phase == PW'(REPEAT_PERIOD - 1)) begin
        phase <= '0;
      end else begin
        phase <= phase + PW'(1);
      end
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank
//   NCH-channel push-button conditioner: shared sample-tick divider plus one
//   debounce_chan per button. Auto-repeat is compiled in with the macro
//   DEBOUNCE_AUTO_REPEAT_EN (off by default).
// Ports
//   CLK     in  1    system clock, rising edge
//   RST     in  1    asynchronous active-high reset
//   BIN     in  NCH  raw button pins, asynchronous to CLK
//   LEVEL   out NCH  debounced state, 1 = pressed
//   PRESS   out NCH  one-cycle pulse on accepted press (and repeats)
//   RELEASE out NCH  one-cycle pulse on accepted release
//   TICK    out 1    one-cycle sample strobe, shared with other slow logic

module debounce_bank
  import debounce_pkg::*;
#(
  parameter int NCH           = 3,
  parameter int CLK_HZ        = 50000000,
  parameter int SAMPLE_HZ     = 1000,
  parameter int STABLE        = 8,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY  = 500,
  parameter int REPEAT_PERIOD = 100
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [NCH-1:0] BIN,
  output logic [NCH-1:0] LEVEL,
  output logic [NCH-1:0] PRESS,
  output logic [NCH-1:0] RELEASE,
  output logic           TICK
);

  localparam int DIV = calc_div(CLK_HZ, SAMPLE_HZ);
  localparam int DW  = clog2(DIV);

  if (DIV < 2) begin : g_bad_div
    $error("debounce_bank: CLK_HZ / SAMPLE_HZ must be at least 2");
  end

  logic [DW-1:0] div_cnt;

  // Free-running divider; TICK is registered so it lands on the cycle after
  // the count reaches DIV-1.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      div_cnt <= '0;
      TICK    <= 1'b0;
    end else begin
      TICK <= (div_cnt == DW'(DIV - 1));
      if (div_cnt == DW'(DIV - 1)) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    debounce_chan #(
      .STABLE       (STABLE),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_chan (
      .CLK  (CLK),
      .RST  (RST),
      .tick (TICK),
      .pin  (BIN[i]),
      .level(LEVEL[i]),
      .press(PRESS[i]),
      .rel  (RELEASE[i])
    );
  end

endmodule
